// File: rtl/clk_sel_pkg.sv
// ---------------------------------------------------------------------------
// clk_sel_pkg
//   Shared types and constants for the run-time selectable clock divider.
//   Holds the switch FSM state encoding, the selection and counter widths,
//   and a helper that maps a selection onto its half period in clki cycles.
//
//   Contents:
//     state_e     - switch FSM states RUN / WAIT_FALL / SWITCH
//     NUM_SRC     - number of selectable divide ratios
//     SEL_W       - width of a selection value
//     CNT_W       - width of the shared divider counter (fits the largest DIV)
//     halfPeriod  - half period for a selection, given the three full periods
// ---------------------------------------------------------------------------
package clk_sel_pkg;

  localparam int NUM_SRC = 3;
  localparam int SEL_W   = 2;
  localparam int CNT_W   = 27;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    WAIT_FALL = 2'd1,
    SWITCH    = 2'd2
  } state_e;

  // Selection 3 never becomes active, so it shares the DIV0 leg; that keeps
  // the counter compare well defined for every encoding.
  function automatic logic [CNT_W-1:0] halfPeriod(
    input logic [SEL_W-1:0] selVal,
    input int               div0,
    input int               div1,
    input int               div2
  );
    logic [CNT_W-1:0] half;
    case (selVal)
      2'd1:    half = CNT_W'(div1 / 2);
      2'd2:    half = CNT_W'(div2 / 2);
      default: half = CNT_W'(div0 / 2);
    endcase
    return half;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
//   Brings a raw push button into the clki domain, filters contact bounce and
//   reports each accepted press as a single-cycle pulse.
//
//   Ports:
//     clk_i   - system clock
//     rst_ni  - asynchronous active-low reset
//     btn_i   - raw asynchronous button level
//     req_o   - one-cycle pulse when the filtered level goes 0 -> 1
//
//   Parameter:
//     DEB_CYCLES - consecutive equal synchronised samples needed before the
//                  filtered (stable) level follows the input
// ---------------------------------------------------------------------------
module btn_debounce #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic req_o
);

  // The counter only has to reach DEB_CYCLES-1; keep at least one bit so a
  // tiny DEB_CYCLES still elaborates.
  localparam int DW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          stable_q;
  logic          stable_d;
  logic [DW-1:0] debCnt_q;
  logic [DW-1:0] debCnt_d;
  logic          pulse_q;
  logic          pulse_d;

  // Two-flop synchroniser plus the filter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      debCnt_q <= '0;
      pulse_q  <= 1'b0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      debCnt_q <= debCnt_d;
      pulse_q  <= pulse_d;
    end
  end

  // debCnt_q counts how many samples in a row have disagreed with the stable
  // level; the sample that would make it DEB_CYCLES flips the stable level.
  // Any agreeing sample restarts the run from zero.
  always_comb begin
    stable_d = stable_q;
    debCnt_d = '0;
    pulse_d  = 1'b0;
    if (sync2_q != stable_q) begin
      if (debCnt_q == DEB_LAST) begin
        stable_d = sync2_q;
        pulse_d  = sync2_q;
      end else begin
        debCnt_d = debCnt_q + DW'(1);
      end
    end
  end

  assign req_o = pulse_q;

endmodule

// File: rtl/clk_sel_ctrl.sv
// ---------------------------------------------------------------------------
// clk_sel_ctrl
//   Glitch-free output clock generator with three run-time selectable divide
//   ratios. One shared counter produces a 50% duty clock; a small FSM defers
//   any ratio change until a falling edge of clko, so the high phase is never
//   cut short and the low phase across a change is the new half period plus
//   one clki cycle.
//
//   Ports:
//     clki        - system clock
//     rst_n       - asynchronous active-low reset (synchronously released)
//     btn_next    - raw push button, each press steps sel to (sel+1) mod 3
//     sel_load    - one-cycle strobe requesting a switch to sel_in
//     sel_in      - target selection for sel_load (3 is ignored)
//     clko        - divided output clock
//     sel         - currently active selection
//     busy        - a switch has been accepted and is not finished yet
//     switch_done - one-cycle pulse in the first cycle showing the new sel
//
//   Parameters:
//     DIV0/DIV1/DIV2 - full clko period in clki cycles (even, >= 2)
//     DEB_CYCLES     - button debounce length in clki cycles
//     INIT_SEL       - selection active after reset (0..2)
// ---------------------------------------------------------------------------
module clk_sel_ctrl
  import clk_sel_pkg::*;
#(
  parameter int DIV0       = 100000000,
  parameter int DIV1       = 50000000,
  parameter int DIV2       = 25000000,
  parameter int DEB_CYCLES = 1000000,
  parameter int INIT_SEL   = 0
) (
  input  logic             clki,
  input  logic             rst_n,
  input  logic             btn_next,
  input  logic             sel_load,
  input  logic [SEL_W-1:0] sel_in,
  output logic             clko,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             switch_done
);

  localparam logic [SEL_W-1:0] SEL_RST  = SEL_W'(INIT_SEL);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_SRC - 1);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             clko_q;
  logic             clko_d;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] sel_d;
  logic [SEL_W-1:0] target_q;
  logic [SEL_W-1:0] target_d;
  logic             busy_q;
  logic             busy_d;
  logic             done_q;
  logic             done_d;

  logic             reqBtn;
  logic [CNT_W-1:0] halfCur;
  logic             phaseEnd;
  logic             loadValid;
  logic [SEL_W-1:0] selNext;

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_btn_debounce (
    .clk_i  (clki),
    .rst_ni (rst_n),
    .btn_i  (btn_next),
    .req_o  (reqBtn)
  );

  // The divider always follows the currently active selection; the new ratio
  // only becomes visible here once SWITCH has written sel_q.
  assign halfCur   = halfPeriod(sel_q, DIV0, DIV1, DIV2);
  assign phaseEnd  = (cnt_q == halfCur - CNT_W'(1));
  assign loadValid = sel_load && (sel_in != 2'd3);
  assign selNext   = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);

  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      clko_q   <= 1'b0;
      sel_q    <= SEL_RST;
      target_q <= SEL_RST;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      clko_q   <= clko_d;
      sel_q    <= sel_d;
      target_q <= target_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // The divider runs in RUN and WAIT_FALL alike. WAIT_FALL just watches for
  // the phase end that drops clko; if clko was low on entry that same compare
  // first raises it and the following high phase runs to completion.
  // SWITCH freezes clko low and restarts the counter so the first low phase
  // at the new ratio is a full half period on top of this one cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    clko_d   = clko_q;
    sel_d    = sel_q;
    target_d = target_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    if (phaseEnd) begin
      cnt_d  = '0;
      clko_d = ~clko_q;
    end

    unique case (state_q)
      RUN: begin
        if (loadValid) begin
          target_d = sel_in;
          busy_d   = 1'b1;
          state_d  = WAIT_FALL;
        end else if (reqBtn) begin
          target_d = selNext;
          busy_d   = 1'b1;
          state_d  = WAIT_FALL;
        end
      end
      WAIT_FALL: begin
        if (phaseEnd && clko_q) begin
          state_d = SWITCH;
        end
      end
      SWITCH: begin
        sel_d   = target_q;
        cnt_d   = '0;
        clko_d  = 1'b0;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  assign clko        = clko_q;
  assign sel         = sel_q;
  assign busy        = busy_q;
  assign switch_done = done_q;

endmodule

// File: tb/tb_clk_sel_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clk_sel_ctrl
//   Self-checking bench for clk_sel_ctrl with small divide ratios. A cycle
//   model predicts all outputs each clki edge into a queue that is compared on
//   the following falling edge; a vector table plus hand sequences cover the
//   selection paths, request priority, debounce filtering and reset abort.
// ---------------------------------------------------------------------------
module tb_clk_sel_ctrl;

  localparam int DIV0     = 8;
  localparam int DIV1     = 4;
  localparam int DIV2     = 2;
  localparam int DEB      = 4;
  localparam int INIT_SEL = 0;

  logic       clki;
  logic       rstN;
  logic       btnNext;
  logic       selLoad;
  logic [1:0] selIn;
  logic       clko;
  logic [1:0] selOut;
  logic       busy;
  logic       switchDone;

  int checkCount;
  int passCount;
  int doneSeen;

  logic [4:0] sbQ[$];

  // Cycle model state
  logic mLvl;
  int   mRemain;
  int   mSel;
  int   mTarget;
  int   mMode;
  logic mBusy;
  logic mDone;
  logic mSync1;
  logic mSync2;
  logic mStable;
  int   mRun;
  logic mReq;

  typedef struct {
    logic       btn;
    logic       load;
    logic [1:0] selIn;
    int         expSel;
    int         expDones;
  } vec_t;

  vec_t vecs[8];

  clk_sel_ctrl #(
    .DIV0       (DIV0),
    .DIV1       (DIV1),
    .DIV2       (DIV2),
    .DEB_CYCLES (DEB),
    .INIT_SEL   (INIT_SEL)
  ) dut (
    .clki        (clki),
    .rst_n       (rstN),
    .btn_next    (btnNext),
    .sel_load    (selLoad),
    .sel_in      (selIn),
    .clko        (clko),
    .sel         (selOut),
    .busy        (busy),
    .switch_done (switchDone)
  );

  initial clki = 1'b0;
  always #5 clki = ~clki;

  function automatic int halfOf(input int s);
    case (s)
      1:       return DIV1 / 2;
      2:       return DIV2 / 2;
      default: return DIV0 / 2;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mLvl    = 1'b0;
    mSel    = INIT_SEL;
    mTarget = INIT_SEL;
    mRemain = halfOf(INIT_SEL);
    mMode   = 0;
    mBusy   = 1'b0;
    mDone   = 1'b0;
    mSync1  = 1'b0;
    mSync2  = 1'b0;
    mStable = 1'b0;
    mRun    = 0;
    mReq    = 1'b0;
    sbQ.delete();
  endtask

  // Model: mRemain is the number of edges left until clko toggles.
  // mMode 0 = running, 1 = waiting for a falling edge, 2 = switch cycle.
  task automatic modelStep();
    logic reqNow;
    logic newReq;
    logic fell;
    reqNow = mReq;
    newReq = 1'b0;
    if (mSync2 != mStable) begin
      mRun++;
      if (mRun == DEB) begin
        mStable = mSync2;
        mRun    = 0;
        newReq  = mStable;
      end
    end else begin
      mRun = 0;
    end
    mSync2 = mSync1;
    mSync1 = btnNext;
    mReq   = newReq;

    if (mMode == 2) begin
      mSel    = mTarget;
      mDone   = 1'b1;
      mBusy   = 1'b0;
      mLvl    = 1'b0;
      mRemain = halfOf(mSel);
      mMode   = 0;
    end else begin
      mDone = 1'b0;
      fell  = mLvl && (mRemain == 1);
      mRemain--;
      if (mRemain == 0) begin
        mLvl    = ~mLvl;
        mRemain = halfOf(mSel);
      end
      if (mMode == 1) begin
        if (fell) mMode = 2;
      end else if (selLoad && selIn != 2'd3) begin
        mTarget = int'(selIn);
        mBusy   = 1'b1;
        mMode   = 1;
      end else if (reqNow) begin
        mTarget = (mSel + 1) % 3;
        mBusy   = 1'b1;
        mMode   = 1;
      end
    end
    sbQ.push_back({mLvl, 2'(mSel), mBusy, mDone});
  endtask

  initial begin
    modelReset();
    forever begin
      @(posedge clki);
      if (rstN === 1'b1) modelStep();
    end
  end

  initial begin
    logic [4:0] exp;
    forever begin
      @(negedge clki);
      if (switchDone === 1'b1) doneSeen++;
      if (sbQ.size() > 0) begin
        exp = sbQ.pop_front();
        checkOutput("scoreboard", 32'({clko, selOut, busy, switchDone}), 32'(exp));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clki);
  endtask

  task automatic doReset();
    #1;
    rstN    = 1'b0;
    btnNext = 1'b0;
    selLoad = 1'b0;
    selIn   = 2'd0;
    modelReset();
    #1;
    checkOutput("reset_outputs", 32'({clko, selOut, busy, switchDone}), 32'({1'b0, 2'(INIT_SEL), 1'b0, 1'b0}));
    idle(2);
    rstN = 1'b1;
  endtask

  task automatic waitClko(input logic level, input string name);
    int n;
    n = 0;
    while (clko !== level && n < 40) begin
      @(negedge clki);
      n++;
    end
    if (clko !== level) checkOutput(name, 32'(clko), 32'(level));
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    int doneBefore;
    doneBefore = doneSeen;
    if (v.btn) begin
      btnNext = 1'b1;
      idle(8);
      btnNext = 1'b0;
      idle(26);
    end else if (v.load) begin
      selLoad = 1'b1;
      selIn   = v.selIn;
      idle(1);
      selLoad = 1'b0;
      idle(20);
    end
    checkOutput($sformatf("vec%0d_sel", idx), 32'(selOut), 32'(v.expSel));
    checkOutput($sformatf("vec%0d_busy", idx), 32'(busy), 32'd0);
    checkOutput($sformatf("vec%0d_dones", idx), 32'(doneSeen - doneBefore), 32'(v.expDones));
  endtask

  initial begin
    logic expClko[8];
    logic expBusy[8];
    int   expSelB[8];
    logic expDone[8];
    int   doneBefore;

    checkCount = 0;
    passCount  = 0;
    doneSeen   = 0;
    rstN       = 1'b0;
    btnNext    = 1'b0;
    selLoad    = 1'b0;
    selIn      = 2'd0;

    vecs[0] = '{1'b1, 1'b0, 2'd0, 1, 1};
    vecs[1] = '{1'b1, 1'b0, 2'd0, 2, 1};
    vecs[2] = '{1'b1, 1'b0, 2'd0, 0, 1};
    vecs[3] = '{1'b0, 1'b1, 2'd3, 0, 0};
    vecs[4] = '{1'b0, 1'b1, 2'd1, 1, 1};
    vecs[5] = '{1'b0, 1'b1, 2'd0, 0, 1};
    vecs[6] = '{1'b0, 1'b1, 2'd0, 0, 1};
    vecs[7] = '{1'b0, 1'b1, 2'd2, 2, 1};

    expClko = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    expBusy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    expSelB = '{0, 0, 0, 0, 2, 2, 2, 2};
    expDone = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    $display("[TB] start");

    // Free run after reset: 4 low, then 4 high / 4 low
    @(negedge clki);
    doReset();
    for (int k = 1; k <= 16; k++) begin
      @(negedge clki);
      checkOutput($sformatf("freerun_clko_%0d", k), 32'(clko), 32'((k / 4) % 2));
    end

    // Load sel 2 one cycle into a high phase
    waitClko(1'b0, "wait_low");
    waitClko(1'b1, "wait_rise");
    selLoad = 1'b1;
    selIn   = 2'd2;
    for (int k = 0; k < 8; k++) begin
      @(negedge clki);
      selLoad = 1'b0;
      checkOutput($sformatf("load2_clko_%0d", k), 32'(clko), 32'(expClko[k]));
      checkOutput($sformatf("load2_busy_%0d", k), 32'(busy), 32'(expBusy[k]));
      checkOutput($sformatf("load2_sel_%0d", k), 32'(selOut), 32'(expSelB[k]));
      checkOutput($sformatf("load2_done_%0d", k), 32'(switchDone), 32'(expDone[k]));
    end

    // Short button glitches are filtered, a long hold steps once
    doReset();
    doneBefore = doneSeen;
    btnNext = 1'b1; idle(3);
    btnNext = 1'b0; idle(1);
    btnNext = 1'b1; idle(3);
    btnNext = 1'b0; idle(12);
    checkOutput("glitch_sel", 32'(selOut), 32'd0);
    checkOutput("glitch_dones", 32'(doneSeen - doneBefore), 32'd0);
    btnNext = 1'b1; idle(6);
    btnNext = 1'b0; idle(24);
    checkOutput("hold_sel", 32'(selOut), 32'd1);
    checkOutput("hold_dones", 32'(doneSeen - doneBefore), 32'd1);

    // Vector table from sel 0
    doReset();
    for (int i = 0; i < 8; i++) applyStimulus(vecs[i], i);

    // sel_load coinciding with the button request: load wins
    doReset();
    doneBefore = doneSeen;
    btnNext = 1'b1;
    idle(6);
    selLoad = 1'b1;
    selIn   = 2'd2;
    idle(1);
    selLoad = 1'b0;
    idle(4);
    btnNext = 1'b0;
    idle(24);
    checkOutput("prio_sel", 32'(selOut), 32'd2);
    checkOutput("prio_dones", 32'(doneSeen - doneBefore), 32'd1);

    // Second load while busy is dropped
    doReset();
    doneBefore = doneSeen;
    selLoad = 1'b1;
    selIn   = 2'd1;
    idle(1);
    selIn   = 2'd2;
    idle(1);
    selLoad = 1'b0;
    idle(20);
    checkOutput("busy_load_sel", 32'(selOut), 32'd1);
    checkOutput("busy_load_dones", 32'(doneSeen - doneBefore), 32'd1);

    // Reset during WAIT_FALL aborts the switch
    doReset();
    waitClko(1'b0, "abort_wait_low");
    selLoad = 1'b1;
    selIn   = 2'd2;
    idle(1);
    selLoad = 1'b0;
    waitClko(1'b1, "abort_wait_rise");
    checkOutput("abort_busy_before", 32'(busy), 32'd1);
    doneBefore = doneSeen;
    doReset();
    idle(30);
    checkOutput("abort_sel_after", 32'(selOut), 32'd0);
    checkOutput("abort_dones_after", 32'(doneSeen - doneBefore), 32'd0);

    idle(2);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/clk_sel_ctrl.md
Name: clk_sel_ctrl

Overview:
- Single output-clock source whose rate is chosen from three divide ratios, selectable at run time.
- A user can step through the ratios with a push button; a host can also load a ratio directly.
- Uses one shared divider counter and a switch FSM, so a ratio change only takes effect on a falling edge of clko. No runt pulse and no truncated high phase ever reaches clko.
- Sits between the board clock and the LED/pulse-output logic; it replaces fixed parallel dividers.

Parameters:
- DIV0, 100000000, full clko period in clki cycles for selection 0 (even, >=2)
- DIV1, 50000000, full clko period for selection 1 (even, >=2)
- DIV2, 25000000, full clko period for selection 2 (even, >=2)
- DEB_CYCLES, 1000000, number of clki cycles btn_next must be stable before it is accepted
- INIT_SEL, 0, selection loaded at reset (0..2)

Ports:
- clki  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- btn_next  in  1  raw asynchronous push button; a press advances the selection
- sel_load  in  1  one-cycle strobe: request a switch to sel_in
- sel_in  in  2  target selection for sel_load; value 3 is ignored
- clko  out  1  divided output clock, 50% duty cycle
- sel  out  2  currently active selection
- busy  out  1  high while a switch is pending
- switch_done  out  1  one-cycle pulse on the cycle sel updates

Behaviour:
- Reset (async assert, sync release):
  - clko=0, sel=INIT_SEL, busy=0, switch_done=0
  - counter cnt=0, state=RUN
  - debouncer cleared; stable level is 0
- Divider:
  - HALF = DIV[sel]/2.
  - cnt increments every clki cycle.
  - When cnt==HALF-1: clko toggles and cnt<=0.
  - cnt is 27 bits; this is sized for the largest DIV.
- btn_next path:
  - 2-FF synchroniser, then debounce counter.
  - The stable level changes only after DEB_CYCLES consecutive equal samples.
  - A 0->1 change of the stable level produces a one-cycle req_btn.
- Request priority in RUN:
  - sel_load with sel_in<=2 wins over req_btn in the same cycle; target = sel_in.
  - Otherwise req_btn sets target = (sel+1) mod 3.
  - sel_load with sel_in==3 is ignored entirely.
  - A target equal to sel still performs the full switch sequence.
- FSM:
  - RUN: on an accepted request, latch target, set busy=1, go to WAIT_FALL. The divider keeps running.
  - WAIT_FALL:
    - The divider runs at the old ratio.
    - On the cycle cnt==HALF-1 with clko==1, clko drops to 0 and the FSM goes to SWITCH.
    - If clko was low on entry, the full low phase and the following high phase complete first.
  - SWITCH (exactly 1 cycle): sel<=target, cnt<=0, clko held 0, switch_done=1, busy<=0, go to RUN.
  - Net effect: the low phase across a switch is the new HALF plus 1 clki cycle. High phases are never shortened.
- Requests arriving in WAIT_FALL or SWITCH are dropped, both button and sel_load. Debounce keeps running, so a press during busy is lost, not queued.
- Reset asserted mid-switch aborts it: sel returns to INIT_SEL and the pending target is discarded.
- Latency: a request in RUN reaches sel/switch_done at most DIV_old + 1 cycles later.

Decomposition:
- Package clk_sel_pkg holds:
  - state enum {RUN, WAIT_FALL, SWITCH}
  - NUM_SRC=3, SEL_W=2, CNT_W=27
  - a function returning the half period for a given sel from the three parameters
- Sub-module btn_debounce (synchroniser + stable counter + rising-edge pulse), parameterised by DEB_CYCLES.
- Everything else lives in the top module.

Test Plan (DIV0=8, DIV1=4, DIV2=2, DEB_CYCLES=4, INIT_SEL=0):
- Reset, then free run:
  - clko=0 until 4 cycles after release, then 4 high / 4 low repeating.
  - sel=0, busy=0 throughout.
- sel_load=1, sel_in=2 issued 1 cycle into a high phase:
  - busy=1; clko stays high 3 more cycles, then falls.
  - Next cycle: SWITCH, sel=2, switch_done=1.
  - clko low 2 cycles, then toggles every 1 cycle.
- btn_next pulses high for 3 cycles, low, high 3 cycles:
  - no req_btn, sel unchanged.
  - Then held high 6 cycles: one switch, sel 0->1.
- Three clean presses from sel=0 with switches completing:
  - sel sequence 0->1->2->0, exactly three switch_done pulses.
- Edge cases:
  - sel_load with sel_in=3: no busy, no change.
  - sel_load (sel_in=1) and req_btn in the same cycle from sel=0: target=1.
  - Second sel_load while busy: ignored.
- rst_n asserted during WAIT_FALL with target 2:
  - immediately clko=0, sel=0, busy=0.
  - After release: normal DIV0 output, no switch.
